cve2_mac_sequencer: RTL
=======================

Name: cve2_mac_sequencer

Overview:
Sequences a MAC instruction (rd = a*b + c) through the shared CVE2 ALU. A MUL pass is followed by an ADD pass, and the result is then held in a registered output with a valid/ready handshake. The block sits between the ID-stage decoder and the ALU operator/operand inputs. It is transparent for non-MAC operations and stalls the pipeline while a MAC is in flight. It also keeps a saturating count of completed MACs.

Parameters:
Width, 32, datapath width of operands and result
CntWidth, 16, width of the completed-MAC counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
alu_operator_i  in  cve2_pkg::alu_op_e  decoded operator from ID
mac_valid_i  in  1  instruction valid; qualifies a MAC request when alu_operator_i == ALU_MAC
mac_ready_o  out  1  MAC request accepted this cycle
operand_a_i  in  Width  multiplicand / pass-through operand A
operand_b_i  in  Width  multiplier / pass-through operand B
operand_c_i  in  Width  addend
flush_i  in  1  kill any in-flight MAC
alu_operator_o  out  cve2_pkg::alu_op_e  operator driven to ALU
alu_operand_a_o  out  Width  operand A driven to ALU
alu_operand_b_o  out  Width  operand B driven to ALU
alu_result_i  in  Width  combinational ALU result, same cycle
result_valid_o  out  1  MAC result available
result_o  out  Width  MAC result
result_ready_i  in  1  consumer accepts result
stall_o  out  1  MAC in progress; ID must hold
mac_count_o  out  CntWidth  completed-MAC count, saturating

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- On rst_i at a clk_i edge:
  - state goes to IDLE;
  - a_q/b_q/c_q/prod_q/res_q are cleared to 0;
  - mac_count_o is cleared to 0.
- rst_i overrides flush_i and all other inputs. Reset mid-operation discards the operation with no result.
- From the first cycle after reset: result_valid_o=0, result_o=0, stall_o=0, mac_ready_o=!flush_i, mac_count_o=0.
- States: IDLE, MUL, ADD, RESP (2-bit encoding).
- IDLE:
  - alu_operator_o=alu_operator_i, alu_operand_a_o=operand_a_i, alu_operand_b_o=operand_b_i (pure pass-through).
  - mac_ready_o = !flush_i.
  - Accept when mac_valid_i && alu_operator_i==ALU_MAC && !flush_i. On accept, capture a/b/c into a_q/b_q/c_q and go to MUL.
  - Any other operator with mac_valid_i is ignored and stays in pass-through.
- MUL:
  - Drive alu_operator_o=ALU_MUL, operands a_q and b_q.
  - Register prod_q <= alu_result_i (low Width bits); go to ADD.
- ADD:
  - Drive ALU_ADD, operands prod_q and c_q.
  - Register res_q <= alu_result_i; go to RESP.
- RESP:
  - ALU outputs return to pass-through.
  - result_valid_o=1, result_o=res_q; both are held stable until result_ready_i.
  - On result_ready_i: go to IDLE and increment mac_count_o unless it is all-ones (saturate).
- Handshake outputs:
  - mac_ready_o=0 in every state except IDLE.
  - stall_o = (state != IDLE).
- Latency:
  - Request accepted at edge N; result_valid_o is high in cycle N+3.
  - Earliest next accept is the cycle after the result handshake, giving a minimum of 4 cycles per MAC.
  - There is no accept in the same cycle as the RESP handshake.
- Arithmetic: all results are modulo 2^Width; high product bits are discarded. The counter is modulo-free and saturating.
- flush_i in MUL/ADD/RESP:
  - Next state is IDLE.
  - The in-flight result is dropped: no result_valid_o, no count increment.
  - flush_i in RESP takes priority over a simultaneous result_ready_i, and the count is not incremented.
- Illegal state encoding goes to IDLE on the next cycle.

Test Plan:
- Basic MAC: a=3, b=5, c=7, accepted at cycle 0 with result_ready_i=1 → ALU sees MUL(3,5) at cycle 1 and ADD(15,7) at cycle 2. result_valid_o=1 with result_o=22 at cycle 3; stall_o=1 for cycles 1–3; mac_count_o=1 at cycle 4.
- Overflow: a=0xFFFF_FFFF, b=2, c=3 → result_o=0x0000_0001.
- Backpressure: result_ready_i=0 for 5 cycles in RESP → result_valid_o and result_o are stable, mac_ready_o=0 and stall_o=1 throughout. mac_count_o increments only on the handshake cycle.
- Flush: flush_i asserted in MUL → IDLE next cycle, result_valid_o never rises, mac_count_o unchanged. A following MAC (2*2+1) returns 5.
- Pass-through: alu_operator_i=ALU_SUB, mac_valid_i=1, operands 9/4 → alu_operator_o=ALU_SUB with operands 9/4 in the same cycle, mac_ready_o=1, no state change.
- Saturation and reset: with CntWidth=2, complete 5 MACs → mac_count_o=3. Asserting rst_i during ADD → all outputs at reset values the next cycle and no result is produced.

Source files
------------

// File: rtl/cve2_mac_sequencer.sv
// MAC sequencer: runs rd = a*b + c as a MUL pass then an ADD pass on the shared ALU,
// holds the result behind a valid/ready handshake and counts completed MACs.
package cve2_pkg;
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SLL,
        ALU_SRL,
        ALU_MUL,
        ALU_MAC
    } alu_op_e;
endpackage

module cve2_mac_sequencer #(
    parameter int unsigned Width    = 32,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  cve2_pkg::alu_op_e   alu_operator_i,
    input  logic                mac_valid_i,
    output logic                mac_ready_o,
    input  logic [Width-1:0]    operand_a_i,
    input  logic [Width-1:0]    operand_b_i,
    input  logic [Width-1:0]    operand_c_i,
    input  logic                flush_i,
    output cve2_pkg::alu_op_e   alu_operator_o,
    output logic [Width-1:0]    alu_operand_a_o,
    output logic [Width-1:0]    alu_operand_b_o,
    input  logic [Width-1:0]    alu_result_i,
    output logic                result_valid_o,
    output logic [Width-1:0]    result_o,
    input  logic                result_ready_i,
    output logic                stall_o,
    output logic [CntWidth-1:0] mac_count_o
);
    import cve2_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        ADD  = 2'b10,
        RESP = 2'b11
    } state_e;

    state_e              state_q;
    logic [Width-1:0]    a_q, b_q, c_q, prod_q, res_q;
    logic [CntWidth-1:0] cnt_q;
    logic                accept;

    assign accept = (state_q == IDLE) && mac_valid_i &&
                    (alu_operator_i == ALU_MAC) && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= operand_a_i;
                        b_q     <= operand_b_i;
                        c_q     <= operand_c_i;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    prod_q  <= alu_result_i;
                    state_q <= flush_i ? IDLE : ADD;
                end
                ADD: begin
                    res_q   <= alu_result_i;
                    state_q <= flush_i ? IDLE : RESP;
                end
                RESP: begin
                    // flush wins over a simultaneous handshake: result dropped, not counted
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (result_ready_i) begin
                        state_q <= IDLE;
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        alu_operator_o  = alu_operator_i;
        alu_operand_a_o = operand_a_i;
        alu_operand_b_o = operand_b_i;
        case (state_q)
            MUL: begin
                alu_operator_o  = ALU_MUL;
                alu_operand_a_o = a_q;
                alu_operand_b_o = b_q;
            end
            ADD: begin
                alu_operator_o  = ALU_ADD;
                alu_operand_a_o = prod_q;
                alu_operand_b_o = c_q;
            end
            default: ;
        endcase
    end

    assign mac_ready_o    = (state_q == IDLE) && !flush_i;
    assign stall_o        = (state_q != IDLE);
    assign result_valid_o = (state_q == RESP);
    assign result_o       = res_q;
    assign mac_count_o    = cnt_q;

endmodule
